// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: program memory loaded by the debug unit, plus the IF/ID pipeline register.
// Also holds the sticky halt flag and a saturating count of program-load writes.
module if_fetch_stage #(
    parameter int                 NBITS     = 32,
    parameter int                 MEM_DEPTH = 256,
    parameter logic [NBITS-1:0]   HALT_WORD = 32'hFFFF_FFFF,
    localparam int                ADDR_BITS = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [NBITS-1:0]      i_PC,
    input  logic                  i_load_en,
    input  logic [ADDR_BITS-1:0]  i_load_addr,
    input  logic [NBITS-1:0]      i_load_data,
    output logic [NBITS-1:0]      o_instruction,
    output logic [NBITS-1:0]      o_PC_plus1,
    output logic                  o_valid,
    output logic                  o_halt,
    output logic [ADDR_BITS:0]    o_loaded_words
);

    localparam logic [ADDR_BITS:0] LOAD_FULL = (ADDR_BITS+1)'(MEM_DEPTH);

    logic [NBITS-1:0]     r_mem [MEM_DEPTH];
    logic [NBITS-1:0]     r_instruction;
    logic [NBITS-1:0]     r_pc_plus1;
    logic                 r_valid;
    logic                 r_halt;
    logic [ADDR_BITS:0]   r_loaded_words;

    logic [NBITS-1:0]     w_fetch_word;
    logic [NBITS-1:0]     w_pc_plus1;
    logic                 w_hold;

    // Asynchronous read; the write below is non-blocking, so a same-edge fetch sees the old word.
    assign w_fetch_word = r_mem[i_PC[ADDR_BITS-1:0]];
    assign w_pc_plus1   = i_PC + NBITS'(1);
    assign w_hold       = !i_enable || r_halt;

    always_ff @(posedge i_clk) begin
        if (i_load_en) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instruction <= '0;
            r_pc_plus1    <= '0;
            r_valid       <= 1'b0;
            r_halt        <= 1'b0;
        end else if (w_hold) begin
            r_instruction <= r_instruction;
        end else if (i_flush) begin
            r_instruction <= '0;
            r_valid       <= 1'b0;
        end else if (!i_stall) begin
            r_instruction <= w_fetch_word;
            r_pc_plus1    <= w_pc_plus1;
            r_valid       <= 1'b1;
            if (w_fetch_word == HALT_WORD) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Counts every load write, saturating once the whole memory could have been filled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_loaded_words <= '0;
        end else if (i_load_en && (r_loaded_words != LOAD_FULL)) begin
            r_loaded_words <= r_loaded_words + 1'b1;
        end
    end

    assign o_instruction  = r_instruction;
    assign o_PC_plus1     = r_pc_plus1;
    assign o_valid        = r_valid;
    assign o_halt         = r_halt;
    assign o_loaded_words = r_loaded_words;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table followed by randomized
// traffic compared against a behavioural model of the fetch stage.
module tb_if_fetch_stage;

    localparam int          NBITS     = 32;
    localparam int          MEM_DEPTH = 256;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, enable, stall, flush, loadEn;
    logic [31:0] pc, loadData;
    logic [7:0]  loadAddr;
    logic [31:0] instruction, pcPlus1;
    logic        valid, halt;
    logic [8:0]  loadedWords;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [31:0] mMem [MEM_DEPTH];
    logic [31:0] mInstr, mPc1;
    bit          mValid, mHalt;
    int          mCount;

    typedef struct {
        bit          rst, en, stl, fl;
        logic [31:0] pc;
        bit          ld;
        logic [7:0]  la;
        logic [31:0] ldat;
        logic [31:0] eInstr, ePc1;
        bit          eValid, eHalt;
        int          eCount;
    } vec_t;

    vec_t vecs [21];

    if_fetch_stage #(.NBITS(NBITS), .MEM_DEPTH(MEM_DEPTH), .HALT_WORD(HALT)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_PC           (pc),
        .i_load_en      (loadEn),
        .i_load_addr    (loadAddr),
        .i_load_data    (loadData),
        .o_instruction  (instruction),
        .o_PC_plus1     (pcPlus1),
        .o_valid        (valid),
        .o_halt         (halt),
        .o_loaded_words (loadedWords)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Model advances by the stage's rules: one edge, with the fetch reading memory before the write.
    task automatic modelStep(input bit r, e, s, f, input logic [31:0] p, input bit le,
                             input logic [7:0] la, input logic [31:0] ld);
        logic [31:0] word;
        word = mMem[p % MEM_DEPTH];
        if (r) begin
            mInstr = 0; mPc1 = 0; mValid = 0; mHalt = 0; mCount = 0;
        end else begin
            if (e && !mHalt) begin
                if (f) begin
                    mInstr = 0; mValid = 0;
                end else if (!s) begin
                    mInstr = word; mPc1 = p + 32'd1; mValid = 1;
                    if (word == HALT) mHalt = 1;
                end
            end
            if (le && mCount < MEM_DEPTH) mCount++;
        end
        if (le) mMem[la] = ld;
    endtask

    task automatic applyStimulus(input bit r, e, s, f, input logic [31:0] p, input bit le,
                                 input logic [7:0] la, input logic [31:0] ld);
        reset = r; enable = e; stall = s; flush = f; pc = p;
        loadEn = le; loadAddr = la; loadData = ld;
        modelStep(r, e, s, f, p, le, la, ld);
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " instr"},  instruction, mInstr);
        checkOutput({tag, " pc1"},    pcPlus1, mPc1);
        checkOutput({tag, " valid"},  32'(valid), 32'(mValid));
        checkOutput({tag, " halt"},   32'(halt), 32'(mHalt));
        checkOutput({tag, " count"},  32'(loadedWords), 32'(mCount));
    endtask

    task automatic loadWord(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(0, 0, 0, 0, 32'd0, 1, a, d);
    endtask

    initial begin
        reset = 1; enable = 0; stall = 0; flush = 0; pc = 0;
        loadEn = 0; loadAddr = 0; loadData = 0;
        for (int i = 0; i < MEM_DEPTH; i++) mMem[i] = 32'hxxxx_xxxx;
        mInstr = 0; mPc1 = 0; mValid = 0; mHalt = 0; mCount = 0;
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1, 0, 0, 0, 32'd0, 0, 8'd0, 32'd0);
        checkOutput("reset instr", instruction, 32'd0);
        checkOutput("reset pc1",   pcPlus1, 32'd0);
        checkOutput("reset valid", 32'(valid), 32'd0);
        checkOutput("reset halt",  32'(halt), 32'd0);
        checkOutput("reset count", 32'(loadedWords), 32'd0);

        // Program load with the pipeline disabled
        loadWord(8'd0,   32'h2001_0005);
        loadWord(8'd1,   32'h2002_0003);
        loadWord(8'd2,   32'h0022_1820);
        loadWord(8'd3,   HALT);
        loadWord(8'd5,   32'h0000_0001);
        loadWord(8'd255, 32'h1234_5678);
        checkOutput("load count", 32'(loadedWords), 32'd6);
        checkOutput("load hold valid", 32'(valid), 32'd0);

        //           rst en stl fl  pc             ld la     ldat           eInstr         ePc1          eV eH cnt
        vecs[0]  = '{0, 1, 0, 0, 32'd0,          0, 8'd0, 32'd0,         32'h2001_0005, 32'd1,        1, 0, 6};
        vecs[1]  = '{0, 1, 1, 0, 32'd1,          0, 8'd0, 32'd0,         32'h2001_0005, 32'd1,        1, 0, 6};
        vecs[2]  = '{0, 1, 1, 0, 32'd1,          0, 8'd0, 32'd0,         32'h2001_0005, 32'd1,        1, 0, 6};
        vecs[3]  = '{0, 1, 0, 0, 32'd1,          0, 8'd0, 32'd0,         32'h2002_0003, 32'd2,        1, 0, 6};
        vecs[4]  = '{0, 1, 1, 1, 32'd2,          0, 8'd0, 32'd0,         32'h0000_0000, 32'd2,        0, 0, 6};
        vecs[5]  = '{0, 1, 0, 0, 32'd2,          0, 8'd0, 32'd0,         32'h0022_1820, 32'd3,        1, 0, 6};
        vecs[6]  = '{0, 1, 0, 0, 32'd5,          1, 8'd5, 32'hDEAD_BEEF, 32'h0000_0001, 32'd6,        1, 0, 7};
        vecs[7]  = '{0, 1, 0, 0, 32'd5,          0, 8'd0, 32'd0,         32'hDEAD_BEEF, 32'd6,        1, 0, 7};
        vecs[8]  = '{0, 1, 0, 0, 32'h105,        0, 8'd0, 32'd0,         32'hDEAD_BEEF, 32'h106,      1, 0, 7};
        vecs[9]  = '{0, 1, 0, 0, 32'hFFFF_FFFF,  0, 8'd0, 32'd0,         32'h1234_5678, 32'd0,        1, 0, 7};
        vecs[10] = '{0, 1, 0, 1, 32'd3,          0, 8'd0, 32'd0,         32'h0000_0000, 32'd0,        0, 0, 7};
        vecs[11] = '{0, 1, 1, 0, 32'd3,          0, 8'd0, 32'd0,         32'h0000_0000, 32'd0,        0, 0, 7};
        vecs[12] = '{0, 0, 0, 0, 32'd3,          0, 8'd0, 32'd0,         32'h0000_0000, 32'd0,        0, 0, 7};
        vecs[13] = '{0, 1, 0, 0, 32'd3,          0, 8'd0, 32'd0,         HALT,          32'd4,        1, 1, 7};
        vecs[14] = '{0, 1, 0, 0, 32'd0,          0, 8'd0, 32'd0,         HALT,          32'd4,        1, 1, 7};
        vecs[15] = '{0, 1, 0, 1, 32'd1,          0, 8'd0, 32'd0,         HALT,          32'd4,        1, 1, 7};
        vecs[16] = '{0, 1, 0, 0, 32'd2,          1, 8'd6, 32'h0000_ABCD, HALT,          32'd4,        1, 1, 8};
        vecs[17] = '{1, 1, 0, 0, 32'd0,          1, 8'd7, 32'h0000_0007, 32'h0000_0000, 32'd0,        0, 0, 0};
        vecs[18] = '{0, 1, 0, 0, 32'd0,          0, 8'd0, 32'd0,         32'h2001_0005, 32'd1,        1, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 32'd6,          0, 8'd0, 32'd0,         32'h0000_ABCD, 32'd7,        1, 0, 0};
        vecs[20] = '{0, 1, 0, 0, 32'd7,          0, 8'd0, 32'd0,         32'h0000_0007, 32'd8,        1, 0, 0};

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].stl, vecs[i].fl, vecs[i].pc,
                          vecs[i].ld, vecs[i].la, vecs[i].ldat);
            checkOutput($sformatf("vec%0d instr", i), instruction, vecs[i].eInstr);
            checkOutput($sformatf("vec%0d pc1", i),   pcPlus1, vecs[i].ePc1);
            checkOutput($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].eValid));
            checkOutput($sformatf("vec%0d halt", i),  32'(halt), 32'(vecs[i].eHalt));
            checkOutput($sformatf("vec%0d count", i), 32'(loadedWords), 32'(vecs[i].eCount));
        end

        // Fill the whole memory, then keep loading past saturation
        applyStimulus(1, 0, 0, 0, 32'd0, 0, 8'd0, 32'd0);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            loadWord(8'(i), ($urandom_range(0, 24) == 0) ? HALT : 32'($urandom()));
        end
        checkOutput("fill count", 32'(loadedWords), 32'd256);
        for (int i = 0; i < 44; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 0, 0, 32'($urandom()), 1,
                          8'($urandom()), 32'($urandom()));
        end
        checkOutput("saturate count", 32'(loadedWords), 32'd256);
        checkModel("saturate");

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) == 0,
                          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom()),
                          $urandom_range(0, 4) == 0,
                          8'($urandom()),
                          ($urandom_range(0, 9) == 0) ? HALT : 32'($urandom()));
            checkModel($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter NBITS, default 32: width of the PC, the instruction word and the load data.
REQ-002 Parameter MEM_DEPTH, default 256: instruction memory depth in words; power of two; ADDR_BITS = log2(MEM_DEPTH).
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that stops the pipeline.
REQ-004 Port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port i_reset, input, 1: reset, synchronous and active-high.
REQ-006 Port i_enable, input, 1: global run enable (debug unit step/run).
REQ-007 Port i_stall, input, 1: hazard-unit stall; hold the IF/ID register.
REQ-008 Port i_flush, input, 1: branch/jump taken; inject a bubble.
REQ-009 Port i_PC, input, NBITS: word address from the program counter.
REQ-010 Port i_load_en, input, 1: program-load write strobe from the debug unit.
REQ-011 Port i_load_addr, input, ADDR_BITS: program-load word address.
REQ-012 Port i_load_data, input, NBITS: program-load data word.
REQ-013 Port o_instruction, output, NBITS: IF/ID instruction register.
REQ-014 Port o_PC_plus1, output, NBITS: IF/ID register holding i_PC + 1.
REQ-015 Port o_valid, output, 1: IF/ID holds a real fetched instruction (0 = bubble).
REQ-016 Port o_halt, output, 1: sticky flag, HALT_WORD has been fetched.
REQ-017 Port o_loaded_words, output, ADDR_BITS+1: count of load writes since reset.

Function
REQ-018 Memory SHALL be MEM_DEPTH x NBITS, asynchronous read, synchronous write, contents unaffected by reset.
REQ-019 Fetch address SHALL be i_PC[ADDR_BITS-1:0]; upper PC bits ignored (address wraps modulo MEM_DEPTH).
REQ-020 i_load_en high SHALL write i_load_data to mem[i_load_addr] at the clock edge, independent of i_enable, i_stall and o_halt.
REQ-021 On a same-cycle load write and fetch of the same address, the IF/ID register SHALL capture the old memory contents.
REQ-022 IF/ID update priority per edge: reset > hold (i_enable=0 or o_halt=1) > flush > stall > capture.
REQ-023 Hold: o_instruction, o_PC_plus1 and o_valid SHALL keep their values.
REQ-024 Flush: o_instruction <= 0 (NOP), o_valid <= 0; o_PC_plus1 SHALL keep its value; flush wins over a simultaneous stall.
REQ-025 Capture: o_instruction <= mem[addr], o_PC_plus1 <= i_PC + 1 (modulo 2^NBITS), o_valid <= 1.
REQ-026 Latency: o_instruction SHALL reflect i_PC exactly one clock after the capture edge.
REQ-027 o_halt SHALL set at the same edge at which HALT_WORD is captured, and then stay at 1 until reset; the HALT word SHALL remain in o_instruction.
REQ-028 HALT_WORD SHALL NOT set o_halt when it is flushed or stalled, or when i_enable=0.
REQ-029 o_loaded_words SHALL increment on each load write and saturate at MEM_DEPTH.
REQ-030 i_load_en during run SHALL be legal and SHALL NOT disturb the IF/ID update.

Reset
REQ-031 At a reset edge, o_instruction=0, o_PC_plus1=0, o_valid=0, o_halt=0 and o_loaded_words=0; memory contents are retained.
REQ-032 Reset SHALL override every other input in the same cycle, including i_load_en for the counter (write still occurs, count stays 0).
REQ-033 A reset in mid-run or after a halt SHALL clear o_halt; the next enabled edge SHALL capture normally.

Verification
REQ-034 Load mem[0..3] = 0x20010005, 0x20020003, 0x00221820, HALT_WORD, then run i_PC = 0,1,2,3 with enable -> o_instruction follows one cycle later, o_PC_plus1 = 1,2,3,4, o_halt=1 after the 4th capture and held while i_PC continues to change.
REQ-035 Stall at i_PC=1 for 2 cycles -> o_instruction stays 0x20010005 and o_PC_plus1 stays 1 for 2 cycles, then 0x20020003 is captured.
REQ-036 Flush and stall asserted together at i_PC=2 -> o_instruction=0, o_valid=0, o_PC_plus1 unchanged.
REQ-037 Load write of 0xDEADBEEF to address 5 while fetching i_PC=5 (old value 0x1) -> capture 0x1; the next fetch of 5 -> 0xDEADBEEF.
REQ-038 i_PC = 0x105 with MEM_DEPTH=256 -> fetches mem[5] and o_PC_plus1 = 0x106; i_PC = 0xFFFFFFFF -> o_PC_plus1 = 0.
REQ-039 Perform 300 load writes -> o_loaded_words saturates at 256; reset after halt -> all outputs 0, memory intact, and a refetch returns the loaded data.
